// File: rtl/ramp_dds_if.sv
// Control and sample bundle between the signal-generator core and ramp_dds.
interface ramp_dds_if #(
    parameter int ACC_W = 32,
    parameter int OUT_W = 16
);
    logic             on;
    logic [ACC_W-1:0] freq_word;
    logic [1:0]       mode;
    logic [7:0]       amplitude;
    logic             sync;
    logic [OUT_W-1:0] wave_out;
    logic             wrap;

    modport master (
        output on, freq_word, mode, amplitude, sync,
        input  wave_out, wrap
    );

    modport slave (
        input  on, freq_word, mode, amplitude, sync,
        output wave_out, wrap
    );
endinterface

// File: rtl/ramp_dds.sv
// Phase-accumulator waveform generator (saw up/down, triangle, square) with
// Q10 amplitude scaling; settings reload only at period boundaries.
module ramp_dds #(
    parameter int ACC_W = 32,
    parameter int OUT_W = 16
) (
    input  logic      clk,
    input  logic      rst,
    ramp_dds_if.slave bus
);
    localparam int GAIN_W = 11;
    localparam int PROD_W = OUT_W + GAIN_W;

    typedef enum logic [1:0] {
        SAW_UP   = 2'b00,
        SAW_DOWN = 2'b01,
        TRIANGLE = 2'b10,
        SQUARE   = 2'b11
    } wave_mode_t;

    // Percent to Q10: 10486/1024 ~ 1024/100, so 100% lands on exactly 1024.
    function automatic logic [GAIN_W-1:0] gain_of(input logic [7:0] pct);
        logic [7:0]  clamped;
        logic [21:0] scaled;
        clamped = (pct > 8'd100) ? 8'd100 : pct;
        scaled  = {14'd0, clamped} * 22'd10486;
        return GAIN_W'(scaled >> 10);
    endfunction

    function automatic logic [OUT_W-1:0] shape(input logic [OUT_W-1:0] p,
                                               input wave_mode_t       m);
        logic [OUT_W-1:0] t;
        logic [OUT_W-1:0] r;
        t = {p[OUT_W-2:0], 1'b0};
        case (m)
            SAW_UP:   r = p;
            SAW_DOWN: r = ~p;
            TRIANGLE: r = p[OUT_W-1] ? ~t : t;
            SQUARE:   r = p[OUT_W-1] ? {OUT_W{1'b0}} : {OUT_W{1'b1}};
            default:  r = p;
        endcase
        return r;
    endfunction

    // Gain never exceeds 1024, so the truncated result always fits OUT_W.
    function automatic logic [OUT_W-1:0] scale(input logic [OUT_W-1:0]  s,
                                               input logic [GAIN_W-1:0] g);
        logic [PROD_W-1:0] prod;
        prod = {{GAIN_W{1'b0}}, s} * {{OUT_W{1'b0}}, g};
        return OUT_W'(prod >> 10);
    endfunction

    logic [ACC_W-1:0]  acc_r;
    logic [ACC_W-1:0]  inc_r;
    wave_mode_t        mode_r;
    logic [GAIN_W-1:0] gain_r;
    logic [OUT_W-1:0]  s1_r;
    logic [OUT_W-1:0]  wave_r;
    logic              w0_r;
    logic              wrap_s1_r;
    logic              wrap_r;

    logic [ACC_W:0]    sum_s;
    logic              carry_s;
    logic              load_s;
    logic [OUT_W-1:0]  phase_s;

    // Next phase, carry-out and period-boundary (load) detection.
    always_comb begin
        sum_s   = {1'b0, acc_r} + {1'b0, inc_r};
        carry_s = sum_s[ACC_W];
        load_s  = ~bus.on | bus.sync | carry_s;
        phase_s = acc_r[ACC_W-1 -: OUT_W];
    end

    // Shadow settings register, reloaded only at period boundaries.
    always_ff @(posedge clk) begin
        if (rst) begin
            inc_r  <= {ACC_W{1'b0}};
            mode_r <= SAW_UP;
            gain_r <= {GAIN_W{1'b0}};
        end else if (load_s) begin
            inc_r  <= bus.freq_word;
            mode_r <= wave_mode_t'(bus.mode);
            gain_r <= gain_of(bus.amplitude);
        end
    end

    // Phase accumulator; a sync restart replaces the increment on its edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r <= {ACC_W{1'b0}};
        end else if (!bus.on || bus.sync) begin
            acc_r <= {ACC_W{1'b0}};
        end else begin
            acc_r <= sum_s[ACC_W-1:0];
        end
    end

    // Shape and scale pipeline with the wrap flag travelling alongside.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_r      <= {OUT_W{1'b0}};
            wave_r    <= {OUT_W{1'b0}};
            w0_r      <= 1'b1;
            wrap_s1_r <= 1'b0;
            wrap_r    <= 1'b0;
        end else begin
            s1_r      <= bus.on ? shape(phase_s, mode_r) : {OUT_W{1'b0}};
            wave_r    <= bus.on ? scale(s1_r, gain_r) : {OUT_W{1'b0}};
            w0_r      <= load_s;
            wrap_s1_r <= w0_r & bus.on;
            wrap_r    <= wrap_s1_r & bus.on;
        end
    end

    assign bus.wave_out = wave_r;
    assign bus.wrap     = wrap_r;
endmodule
